alu_issue_stage: RTL and testbench

Registered decode/issue stage that drives the ALU from the instruction side. It accepts a raw 32-bit MIPS instruction plus its two register-file read values, decodes them into the 4-bit ALU operation code and the two ALU operands, and presents them through a valid/ready handshake backed by a 2-entry skid buffer. It sits between register read and the combinational ALU, and is the only producer of ALU control codes in the datapath.

---
 rtl/alu_pkg.sv | 68 ++++++
 rtl/alu_issue_stage_if.sv | 31 +++
 rtl/alu_decode.sv | 103 ++++++++++
 rtl/alu_issue_stage.sv | 72 +++++++
 tb/tb_alu_issue_stage.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared decode constants and the issue-entry payload for the ALU issue stage.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SRL  = 4'd4,
    ALU_AND  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLTU = 4'd8,
    ALU_SLT  = 4'd9
  } alu_code_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_BEQ  = 2'd1,
    BR_BNE  = 2'd2
  } branch_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // One held issue entry: everything the ALU/EX side needs.
  typedef struct packed {
    alu_code_e   code;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  dest;
    branch_e     br;
    logic        illegal;
  } issue_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] imm);
    return {16'b0, imm};
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction-side input handshake and ALU-side output handshake of the issue stage.
interface alu_issue_stage_if;
  logic        Flush;
  logic        InValid;
  logic        InReady;
  logic [31:0] Instr;
  logic [31:0] RsData;
  logic [31:0] RtData;
  logic        OutValid;
  logic        OutReady;
  logic [3:0]  ALU_Control;
  logic [31:0] InputData1;
  logic [31:0] InputData2;
  logic [4:0]  DestReg;
  logic [1:0]  BranchType;
  logic        Illegal;

  // Environment side: register read upstream plus the EX consumer downstream.
  modport master (
    output Flush, InValid, Instr, RsData, RtData, OutReady,
    input  InReady, OutValid, ALU_Control, InputData1, InputData2,
           DestReg, BranchType, Illegal
  );

  // Issue stage side.
  modport slave (
    input  Flush, InValid, Instr, RsData, RtData, OutReady,
    output InReady, OutValid, ALU_Control, InputData1, InputData2,
           DestReg, BranchType, Illegal
  );
endinterface

// File: rtl/alu_decode.sv
// Combinational MIPS decode: raw instruction plus register values to one issue entry.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output issue_t      entry
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt_f;
  logic [4:0]  rd_f;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic        unused_rs_field;

  assign op              = instr[31:26];
  assign rt_f            = instr[20:16];
  assign rd_f            = instr[15:11];
  assign shamt           = instr[10:6];
  assign funct           = instr[5:0];
  assign imm             = instr[15:0];
  // Operand values arrive already read, so the rs register number itself is not needed.
  assign unused_rs_field = ^instr[25:21];

  // Opcode/funct decode; anything unrecognised collapses to an all-zero illegal entry.
  always_comb begin
    logic legal;
    entry = '0;
    legal = 1'b1;
    case (op)
      OP_RTYPE: begin
        entry.dest = rd_f;
        entry.op1  = rs_data;
        entry.op2  = rt_data;
        case (funct)
          FN_ADD, FN_ADDU: entry.code = ALU_ADD;
          FN_SUB, FN_SUBU: entry.code = ALU_SUB;
          FN_AND:          entry.code = ALU_AND;
          FN_OR:           entry.code = ALU_OR;
          FN_NOR:          entry.code = ALU_NOR;
          FN_SLT:          entry.code = ALU_SLT;
          FN_SLTU:         entry.code = ALU_SLTU;
          FN_SLL, FN_SRL: begin
            entry.code = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
            entry.op1  = rt_data;
            entry.op2  = {27'b0, shamt};
          end
          FN_SLLV, FN_SRLV: begin
            entry.code = (funct == FN_SLLV) ? ALU_SLL : ALU_SRL;
            entry.op1  = rt_data;
            entry.op2  = {27'b0, rs_data[4:0]};
          end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW: begin
        entry.code = ALU_ADD;
        entry.op1  = rs_data;
        entry.op2  = sext16(imm);
        entry.dest = rt_f;
      end
      OP_SW: begin
        entry.code = ALU_ADD;
        entry.op1  = rs_data;
        entry.op2  = sext16(imm);
      end
      OP_SLTI, OP_SLTIU: begin
        entry.code = (op == OP_SLTI) ? ALU_SLT : ALU_SLTU;
        entry.op1  = rs_data;
        entry.op2  = sext16(imm);
        entry.dest = rt_f;
      end
      OP_ANDI, OP_ORI: begin
        entry.code = (op == OP_ANDI) ? ALU_AND : ALU_OR;
        entry.op1  = rs_data;
        entry.op2  = zext16(imm);
        entry.dest = rt_f;
      end
      OP_LUI: begin
        // lui is realised as an SLL of the zero-extended immediate by 16.
        entry.code = ALU_SLL;
        entry.op1  = zext16(imm);
        entry.op2  = 32'd16;
        entry.dest = rt_f;
      end
      OP_BEQ, OP_BNE: begin
        entry.code = ALU_SUB;
        entry.op1  = rs_data;
        entry.op2  = rt_data;
        entry.br   = (op == OP_BEQ) ? BR_BEQ : BR_BNE;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      entry         = '0;
      entry.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Registered decode/issue stage: decode feeding a main register backed by one skid entry.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_stage_if.slave   bus
);

  issue_t dec;
  issue_t main_q;
  issue_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   accept;
  logic   drain;
  logic   main_hold;

  alu_decode u_decode (
    .instr   (bus.Instr),
    .rs_data (bus.RsData),
    .rt_data (bus.RtData),
    .entry   (dec)
  );

  // Ready depends only on registered skid state, so OutReady never reaches InReady.
  assign accept    = bus.InValid & ~skid_valid;
  assign drain     = main_valid & bus.OutReady;
  assign main_hold = main_valid & ~bus.OutReady;

  // Entry occupancy; the skid only fills when main is occupied and stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (bus.Flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= accept | skid_valid | main_hold;
      skid_valid <= skid_valid ? ~drain : (accept & main_hold);
    end
  end

  // Payload moves: skid refills main on drain, otherwise new entries land in the free slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (bus.Flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (drain && skid_valid)
        main_q <= skid_q;
      else if (accept && (!main_valid || drain))
        main_q <= dec;
      if (accept && main_hold)
        skid_q <= dec;
    end
  end

  assign bus.InReady     = ~skid_valid;
  assign bus.OutValid    = main_valid;
  assign bus.ALU_Control = main_q.code;
  assign bus.InputData1  = main_q.op1;
  assign bus.InputData2  = main_q.op2;
  assign bus.DestReg     = main_q.dest;
  assign bus.BranchType  = main_q.br;
  assign bus.Illegal     = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: directed scenarios followed by random traffic.
module tb_alu_issue_stage;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [75:0] sb[$];

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [5:0] functs [0:12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27,
                                6'h2A, 6'h2B, 6'h00, 6'h02, 6'h04, 6'h06};
  logic [5:0] iops   [0:11] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F,
                                6'h04, 6'h05, 6'h23, 6'h2B, 6'h3F};

  // Reference: expected {code, op1, op2, dest, branch, illegal} straight from the decode table.
  function automatic logic [75:0] model(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] se;
    logic [31:0] ze;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  code;
    logic [4:0]  dst;
    logic [1:0]  br;
    bit          ok;
    op = ins[31:26];
    fn = ins[5:0];
    ze = {16'h0000, ins[15:0]};
    se = {{16{ins[15]}}, ins[15:0]};
    ok = 1; br = 0; code = 0; dst = ins[20:16]; a = rs; b = rt;
    if (op == 6'h00) begin
      dst = ins[15:11];
      case (fn)
        6'h20, 6'h21: code = 1;
        6'h22, 6'h23: code = 2;
        6'h24: code = 5;
        6'h25: code = 6;
        6'h27: code = 7;
        6'h2A: code = 9;
        6'h2B: code = 8;
        6'h00: begin code = 3; a = rt; b = ins[10:6]; end
        6'h02: begin code = 4; a = rt; b = ins[10:6]; end
        6'h04: begin code = 3; a = rt; b = rs % 32; end
        6'h06: begin code = 4; a = rt; b = rs % 32; end
        default: ok = 0;
      endcase
    end else begin
      case (op)
        6'h08, 6'h09, 6'h23: begin code = 1; b = se; end
        6'h2B: begin code = 1; b = se; dst = 0; end
        6'h0A: begin code = 9; b = se; end
        6'h0B: begin code = 8; b = se; end
        6'h0C: begin code = 5; b = ze; end
        6'h0D: begin code = 6; b = ze; end
        6'h0F: begin code = 3; a = ze; b = 16; end
        6'h04: begin code = 2; dst = 0; br = 1; end
        6'h05: begin code = 2; dst = 0; br = 2; end
        default: ok = 0;
      endcase
    end
    if (!ok) return 76'd1;
    return {code, a, b, dst, br, 1'b0};
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) == 0) return r;
    if ($urandom_range(0, 1) == 0)
      return {6'h00, r[25:6], functs[$urandom_range(0, 12)]};
    return {iops[$urandom_range(0, 11)], r[25:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pop on every output handshake, push on every accepted input; flush/reset empty it.
  always @(negedge clk) begin
    logic [75:0] act;
    logic [75:0] exp;
    if (!rst_n || bus.Flush) begin
      sb.delete();
    end else begin
      if (bus.OutValid && bus.OutReady) begin
        act = {bus.ALU_Control, bus.InputData1, bus.InputData2,
               bus.DestReg, bus.BranchType, bus.Illegal};
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL out_unexpected: got %h with no entry expected", act);
        end else begin
          exp = sb.pop_front();
          if (act !== exp) begin
            n_err++;
            $display("FAIL out_entry: got %h expected %h", act, exp);
          end
        end
      end
      if (bus.InValid && bus.InReady)
        sb.push_back(model(bus.Instr, bus.RsData, bus.RtData));
    end
  end

  // Present one instruction until accepted; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    int k;
    bus.Instr   = ins;
    bus.RsData  = rs;
    bus.RtData  = rt;
    bus.InValid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!bus.InReady && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!bus.InReady) chk("send_timeout", 32'(bus.InReady), 32'd1);
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.InValid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    rst_n        = 1'b0;
    bus.Flush    = 1'b0;
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    bus.Instr    = '0;
    bus.RsData   = '0;
    bus.RtData   = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_outvalid", 32'(bus.OutValid), 32'd0);
    chk("rst_inready", 32'(bus.InReady), 32'd1);
    chk("rst_code", 32'(bus.ALU_Control), 32'd0);
    chk("rst_data1", bus.InputData1, 32'd0);
    chk("rst_data2", bus.InputData2, 32'd0);
    chk("rst_dest", 32'(bus.DestReg), 32'd0);
    chk("rst_branch", 32'(bus.BranchType), 32'd0);
    chk("rst_illegal", 32'(bus.Illegal), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.OutReady = 1'b1;
    idle(1);

    // add $3,$1,$2
    send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd5, 32'd7);
    chk("add_valid", 32'(bus.OutValid), 32'd1);
    chk("add_code", 32'(bus.ALU_Control), 32'd1);
    chk("add_d1", bus.InputData1, 32'd5);
    chk("add_d2", bus.InputData2, 32'd7);
    chk("add_dest", 32'(bus.DestReg), 32'd3);
    // sll $4,$5,3
    send({6'h00, 5'd0, 5'd5, 5'd4, 5'd3, 6'h00}, 32'd99, 32'd1);
    chk("sll_code", 32'(bus.ALU_Control), 32'd3);
    chk("sll_d1", bus.InputData1, 32'd1);
    chk("sll_d2", bus.InputData2, 32'd3);
    // lui $6,0x1234
    send({6'h0F, 5'd0, 5'd6, 16'h1234}, 32'd0, 32'd0);
    chk("lui_code", 32'(bus.ALU_Control), 32'd3);
    chk("lui_d1", bus.InputData1, 32'h1234);
    chk("lui_d2", bus.InputData2, 32'd16);
    chk("lui_dest", 32'(bus.DestReg), 32'd6);
    // addi / ori with imm 0xFFFF
    send({6'h08, 5'd1, 5'd2, 16'hFFFF}, 32'd10, 32'd0);
    chk("addi_d2", bus.InputData2, 32'hFFFF_FFFF);
    chk("addi_dest", 32'(bus.DestReg), 32'd2);
    send({6'h0D, 5'd1, 5'd2, 16'hFFFF}, 32'd10, 32'd0);
    chk("ori_d2", bus.InputData2, 32'h0000_FFFF);
    // illegal funct and illegal opcode
    send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h3F}, 32'd4, 32'd4);
    chk("ill_fn_valid", 32'(bus.OutValid), 32'd1);
    chk("ill_fn_flag", 32'(bus.Illegal), 32'd1);
    chk("ill_fn_code", 32'(bus.ALU_Control), 32'd0);
    send({6'h3F, 26'h123_4567}, 32'd4, 32'd4);
    chk("ill_op_flag", 32'(bus.Illegal), 32'd1);
    chk("ill_op_d1", bus.InputData1, 32'd0);
    idle(2);
    chk("drained_idle", 32'(bus.OutValid), 32'd0);

    // Backpressure: three back-to-back issues, only two held.
    bus.OutReady = 1'b0;
    bus.InValid  = 1'b1;
    bus.Instr = {6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h22}; bus.RsData = 32'd50; bus.RtData = 32'd8;
    @(posedge clk); #1;
    bus.Instr = {6'h00, 5'd1, 5'd2, 5'd9, 5'd0, 6'h25}; bus.RsData = 32'hF0; bus.RtData = 32'h0F;
    @(posedge clk); #1;
    bus.Instr = {6'h0C, 5'd1, 5'd10, 16'h00FF}; bus.RsData = 32'h1234; bus.RtData = 32'd0;
    @(negedge clk);
    chk("full_inready", 32'(bus.InReady), 32'd0);
    chk("full_hold_code", 32'(bus.ALU_Control), 32'd2);
    @(posedge clk); #1;
    bus.InValid  = 1'b0;
    chk("full_hold_d1", bus.InputData1, 32'd50);
    bus.OutReady = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("inready_after_drain", 32'(bus.InReady), 32'd1);
    idle(2);
    chk("bp_drained", 32'(bus.OutValid), 32'd0);

    // Flush with full buffer and an incoming instruction.
    bus.OutReady = 1'b0;
    send({6'h09, 5'd1, 5'd2, 16'h0001}, 32'd1, 32'd0);
    send({6'h09, 5'd1, 5'd3, 16'h0002}, 32'd1, 32'd0);
    bus.InValid = 1'b1;
    bus.Instr   = {6'h09, 5'd1, 5'd4, 16'h0003};
    bus.Flush   = 1'b1;
    @(posedge clk); #1;
    bus.Flush   = 1'b0;
    bus.InValid = 1'b0;
    @(negedge clk);
    chk("flush_outvalid", 32'(bus.OutValid), 32'd0);
    chk("flush_inready", 32'(bus.InReady), 32'd1);
    chk("flush_code", 32'(bus.ALU_Control), 32'd0);
    // Flush on an empty stage drops the instruction presented alongside it.
    @(posedge clk); #1;
    bus.InValid = 1'b1;
    bus.Flush   = 1'b1;
    @(posedge clk); #1;
    bus.Flush   = 1'b0;
    bus.InValid = 1'b0;
    @(negedge clk);
    chk("flush_drop_incoming", 32'(bus.OutValid), 32'd0);

    // Asynchronous reset mid-stream.
    @(posedge clk); #1;
    send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, 32'd5, 32'd7);
    send({6'h0A, 5'd1, 5'd2, 16'h8000}, 32'd3, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_outvalid", 32'(bus.OutValid), 32'd0);
    chk("arst_inready", 32'(bus.InReady), 32'd1);
    chk("arst_code", 32'(bus.ALU_Control), 32'd0);
    chk("arst_d1", bus.InputData1, 32'd0);
    chk("arst_d2", bus.InputData2, 32'd0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Random traffic with random backpressure and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      bus.InValid  = ($urandom_range(0, 3) != 0);
      bus.Instr    = gen_instr();
      bus.RsData   = $urandom;
      bus.RtData   = $urandom;
      bus.OutReady = ($urandom_range(0, 3) != 0);
      bus.Flush    = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    bus.InValid  = 1'b0;
    bus.Flush    = 1'b0;
    bus.OutReady = 1'b1;
    k = 0;
    while (bus.OutValid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    @(negedge clk);
    chk("final_outvalid", 32'(bus.OutValid), 32'd0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
